// File: rtl/fpu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Package : fpu_pkg                                                  |
// | Shared FPU result types: half-precision word and exception flags.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package fpu_pkg;

  localparam int FP16_W = 16;

  typedef logic [FP16_W-1:0] fp16_t;

  typedef struct packed {
    logic overflow;
    logic underflow;
    logic inexact;
  } fpu_flags_t;

  // Tag is appended by users because its width is a per-instance parameter
  typedef struct packed {
    fp16_t      result;
    fpu_flags_t flags;
  } fpu_result_t;

endpackage : fpu_pkg
`default_nettype wire

// File: rtl/fpu_result_ram.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : fpu_result_ram                                           |
// | Result storage: one synchronous write port, one async read port.   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module fpu_result_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 27
) (
  input  logic                     clk,
  input  logic                     i_wr_en,
  input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
  output logic [WIDTH-1:0]         o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Storage is never reset; validity is tracked by the owner's level count
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule : fpu_result_ram
`default_nettype wire

// File: rtl/fpu_result_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : fpu_result_buffer                                        |
// | FWFT FIFO for FPU results with drop-on-full counting and sticky    |
// | exception flags.                                                   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module fpu_result_buffer
  import fpu_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int TAG_W = 8,
  parameter int CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [FP16_W-1:0]          in_result,
  input  logic [2:0]                 in_flags,
  input  logic [TAG_W-1:0]           in_tag,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [FP16_W-1:0]          out_result,
  output logic [2:0]                 out_flags,
  output logic [TAG_W-1:0]           out_tag,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic [2:0]                 sticky_flags,
  input  logic                       clr_sticky,
  output logic [CNT_W-1:0]           drop_cnt
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int LVL_W   = PTR_W + 1;
  localparam int ENTRY_W = $bits(fpu_result_t) + TAG_W;

  localparam logic [LVL_W-1:0] c_FULL_LEVEL = LVL_W'(DEPTH);

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic [2:0]       r_sticky;
  logic [CNT_W-1:0] r_drop_cnt;

  logic             w_full;
  logic             w_not_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_drop;

  fpu_result_t      w_wr_entry;
  fpu_result_t      w_head;
  logic [TAG_W-1:0] w_head_tag;
  logic [ENTRY_W-1:0] w_rd_data;

  // Level register alone decides empty/full; pointers only address storage
  assign w_full      = (r_level == c_FULL_LEVEL);
  assign w_not_empty = (r_level != '0);
  assign w_pop       = w_not_empty && out_ready;
  assign w_push      = in_valid && (!w_full || w_pop);
  assign w_drop      = in_valid && w_full && !w_pop;

  assign w_wr_entry.result = in_result;
  assign w_wr_entry.flags  = in_flags;

  fpu_result_ram #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_ram (
    .clk       (clk),
    .i_wr_en   (w_push),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data ({w_wr_entry, in_tag}),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_rd_data)
  );

  assign {w_head, w_head_tag} = w_rd_data;

  // Pointers and occupancy; pointer increments wrap naturally at DEPTH
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Saturating count of results lost because the buffer was full
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != '1)) begin
      r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end

  // Sticky flags see every valid result, dropped or not; new flags beat clear
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sticky <= '0;
    end else begin
      r_sticky <= (clr_sticky ? 3'b000 : r_sticky) | (in_valid ? in_flags : 3'b000);
    end
  end

  // Head data is zeroed while empty so idle outputs are deterministic
  always_comb begin
    out_valid  = w_not_empty;
    out_result = '0;
    out_flags  = '0;
    out_tag    = '0;
    if (w_not_empty) begin
      out_result = w_head.result;
      out_flags  = w_head.flags;
      out_tag    = w_head_tag;
    end
  end

  assign level        = r_level;
  assign full         = w_full;
  assign sticky_flags = r_sticky;
  assign drop_cnt     = r_drop_cnt;

endmodule : fpu_result_buffer
`default_nettype wire

// File: tb/tb_fpu_result_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : tb_fpu_result_buffer                                     |
// | Directed scenarios plus randomized traffic against a queue model.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_fpu_result_buffer;

  localparam int DEPTH   = 16;
  localparam int TAG_W   = 8;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef logic [15+3+TAG_W:0] ent_t;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic [15:0]      in_result;
  logic [2:0]       in_flags;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      out_result;
  logic [2:0]       out_flags;
  logic [TAG_W-1:0] out_tag;
  logic [4:0]       level;
  logic             full;
  logic [2:0]       sticky_flags;
  logic             clr_sticky;
  logic [CNT_W-1:0] drop_cnt;

  fpu_result_buffer #(
    .DEPTH (DEPTH),
    .TAG_W (TAG_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_result    (in_result),
    .in_flags     (in_flags),
    .in_tag       (in_tag),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_flags    (out_flags),
    .out_tag      (out_tag),
    .level        (level),
    .full         (full),
    .sticky_flags (sticky_flags),
    .clr_sticky   (clr_sticky),
    .drop_cnt     (drop_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: a plain queue plus sticky OR and saturating drop count
  ent_t q[$];
  logic [2:0] m_sticky;
  int         m_drop;
  int         n_checks;
  int         n_pass;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    else
      n_pass++;
  endtask

  task automatic check_all();
    ent_t h;
    h = (q.size() != 0) ? q[0] : '0;
    check("out_valid", 32'(out_valid), 32'(q.size() != 0));
    check("out_result", 32'(out_result), 32'(h[15+3+TAG_W:3+TAG_W]));
    check("out_flags", 32'(out_flags), 32'(h[2+TAG_W:TAG_W]));
    check("out_tag", 32'(out_tag), 32'(h[TAG_W-1:0]));
    check("level", 32'(level), 32'(q.size()));
    check("full", 32'(full), 32'(q.size() == DEPTH));
    check("sticky", 32'(sticky_flags), 32'(m_sticky));
    check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
  endtask

  // Apply one cycle of inputs, advance the model across the edge, then compare
  task automatic step(input logic v, input logic [15:0] res, input logic [2:0] fl,
                      input logic [TAG_W-1:0] tg, input logic rdy, input logic clr,
                      input logic rst_n);
    bit was_full, can_pop;
    in_valid   = v;
    in_result  = res;
    in_flags   = fl;
    in_tag     = tg;
    out_ready  = rdy;
    clr_sticky = clr;
    reset      = rst_n;
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
      m_sticky = 3'b000;
      m_drop   = 0;
    end else begin
      was_full = (q.size() == DEPTH);
      can_pop  = (q.size() != 0) && rdy;
      if (can_pop) void'(q.pop_front());
      if (v && (!was_full || can_pop)) q.push_back({res, fl, tg});
      if (v && was_full && !can_pop && m_drop < CNT_MAX) m_drop++;
      m_sticky = (clr ? 3'b000 : m_sticky) | (v ? fl : 3'b000);
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic push(input logic [15:0] res, input logic [TAG_W-1:0] tg, input logic rdy);
    step(1'b1, res, 3'b000, tg, rdy, 1'b0, 1'b1);
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 16'h0, 3'b000, '0, rdy, 1'b0, 1'b1);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    m_sticky = 3'b000;
    m_drop   = 0;

    // Reset held with traffic present
    step(1'b1, 16'h1234, 3'b111, 8'h55, 1'b1, 1'b0, 1'b0);
    step(1'b1, 16'h1234, 3'b111, 8'h55, 1'b1, 1'b0, 1'b0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_sticky", 32'(sticky_flags), 32'd0);
    check("rst_drop", 32'(drop_cnt), 32'd0);

    // Order
    push(16'h3C00, 8'd0, 1'b0);
    check("first_visible", 32'(out_valid), 32'd1);
    push(16'h4000, 8'd1, 1'b0);
    push(16'h4200, 8'd2, 1'b0);
    check("order_level", 32'(level), 32'd3);
    check("order_head0", 32'(out_result), 32'h3C00);
    idle(1'b1);
    check("order_head1", 32'(out_result), 32'h4000);
    idle(1'b1);
    check("order_head2", 32'(out_result), 32'h4200);
    idle(1'b1);
    check("order_empty", 32'(out_valid), 32'd0);

    // Overflow drop
    for (int i = 0; i < 18; i++) push(16'h3000 + 16'(i), 8'(i), 1'b0);
    check("ovf_full", 32'(full), 32'd1);
    check("ovf_level", 32'(level), 32'd16);
    check("ovf_drop", 32'(drop_cnt), 32'd2);
    for (int i = 0; i < 16; i++) begin
      check("ovf_drain_tag", 32'(out_tag), 32'(i));
      idle(1'b1);
    end

    // Push and pop together at full
    for (int i = 0; i < 16; i++) push(16'h5000 + 16'(i), 8'(32 + i), 1'b0);
    push(16'h5555, 8'd20, 1'b1);
    check("fullpp_level", 32'(level), 32'd16);
    check("fullpp_drop", 32'(drop_cnt), 32'd2);
    for (int i = 0; i < 16; i++) begin
      check("fullpp_tag", 32'(out_tag), (i < 15) ? 32'(33 + i) : 32'd20);
      idle(1'b1);
    end

    // Sticky flags
    step(1'b1, 16'h3C00, 3'b100, 8'd1, 1'b1, 1'b0, 1'b1);
    check("sticky_set", 32'(sticky_flags), 32'b100);
    step(1'b1, 16'h3C00, 3'b001, 8'd2, 1'b1, 1'b1, 1'b1);
    check("sticky_clr_new", 32'(sticky_flags), 32'b001);
    step(1'b0, 16'h0, 3'b000, 8'd0, 1'b1, 1'b1, 1'b1);
    check("sticky_clr", 32'(sticky_flags), 32'b000);

    // Saturation and mid-drain reset
    step(1'b0, 16'h0, 3'b000, 8'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 21; i++) push(16'h6000 + 16'(i), 8'(i), 1'b0);
    check("sat_drop", 32'(drop_cnt), 32'd3);
    idle(1'b1);
    idle(1'b1);
    step(1'b1, 16'h7777, 3'b111, 8'd9, 1'b1, 1'b0, 1'b0);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_level", 32'(level), 32'd0);
    check("mid_rst_full", 32'(full), 32'd0);
    check("mid_rst_drop", 32'(drop_cnt), 32'd0);
    check("mid_rst_sticky", 32'(sticky_flags), 32'd0);

    // Randomized traffic with varying consumer speed
    for (int p = 0; p < 4; p++) begin
      int rdy_pct;
      rdy_pct = (p == 0) ? 15 : (p == 1) ? 50 : (p == 2) ? 80 : 97;
      for (int i = 0; i < 400; i++) begin
        step($urandom_range(0, 99) < 70,
             16'($urandom),
             3'($urandom),
             8'($urandom),
             $urandom_range(0, 99) < rdy_pct,
             $urandom_range(0, 99) < 10,
             $urandom_range(0, 199) != 0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_fpu_result_buffer
`default_nettype wire
